// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiplier result path.
// Holds the default operand width and the unloader state encoding.
package booth_pkg;

    localparam int WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND_LO = 2'd1,
        SEND_HI = 2'd2
    } unload_state_t;

endpackage

// File: rtl/booth_result_unloader_if.sv
// Bundle of the unloader's capture-side and stream-side signals.
// The master modport is the unloader itself; slave is the environment around it.
interface booth_result_unloader_if
    import booth_pkg::*;
#(
    parameter int WIDTH = booth_pkg::WIDTH
);

    logic [2*WIDTH-1:0] product;
    logic               done;
    logic [WIDTH-1:0]   out_data;
    logic               out_valid;
    logic               out_last;
    logic               out_ready;
    logic               busy;
    logic               overflow;
    unload_state_t      dbg_state;

    // A word moves only in a cycle where out_valid && out_ready; once out_valid
    // rises, out_data/out_last stay stable until that handshake happens.
    modport master (
        input  product, done, out_ready,
        output out_data, out_valid, out_last, busy, overflow, dbg_state
    );

    modport slave (
        output product, done, out_ready,
        input  out_data, out_valid, out_last, busy, overflow, dbg_state
    );

endinterface

// File: rtl/booth_result_unloader_product_register.sv
// Loadable holding register for the full-width multiplier product.
// Reset wins over load so a done coincident with reset is ignored.
module product_register #(
    parameter int W = 2 * booth_pkg::WIDTH
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/booth_result_unloader.sv
// Captures a 2*WIDTH product on done and streams it out as two WIDTH words,
// low half first, over a valid/ready handshake with registered outputs.
module booth_result_unloader
    import booth_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    booth_result_unloader_if.master  bus
);

    logic [2*WIDTH-1:0] held_q;
    logic               capture_d;
    logic               drop_d;
    unload_state_t      state_q;
    logic [WIDTH-1:0]   out_data_q;
    logic               out_valid_q;
    logic               out_last_q;
    logic               busy_q;
    logic               overflow_q;

    // Capture is allowed only when the holding register is free or is freed
    // by the high-half handshake in this same cycle.
    assign capture_d = bus.done &&
                       ((state_q == IDLE) || ((state_q == SEND_HI) && bus.out_ready));
    assign drop_d    = bus.done &&
                       ((state_q == SEND_LO) || ((state_q == SEND_HI) && !bus.out_ready));

    product_register #(
        .W (2 * WIDTH)
    ) u_product_register (
        .clk    (clk),
        .reset  (reset),
        .load_i (capture_d),
        .d_i    (bus.product),
        .q_o    (held_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            if (drop_d) begin
                overflow_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (bus.done) begin
                        state_q     <= SEND_LO;
                        out_data_q  <= bus.product[WIDTH-1:0];
                        out_valid_q <= 1'b1;
                        out_last_q  <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                SEND_LO: begin
                    if (bus.out_ready) begin
                        state_q    <= SEND_HI;
                        out_data_q <= held_q[2*WIDTH-1:WIDTH];
                        out_last_q <= 1'b1;
                    end
                end
                SEND_HI: begin
                    if (bus.out_ready) begin
                        if (bus.done) begin
                            state_q    <= SEND_LO;
                            out_data_q <= bus.product[WIDTH-1:0];
                            out_last_q <= 1'b0;
                        end else begin
                            state_q     <= IDLE;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            busy_q      <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    out_last_q  <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.busy      = busy_q;
    assign bus.overflow  = overflow_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_booth_result_unloader.sv
// Randomized and directed bench for booth_result_unloader against a queue model
// of the words still owed downstream.
module tb_booth_result_unloader;
    import booth_pkg::*;

    localparam int W = 16;

    logic clk;
    logic reset;

    booth_result_unloader_if #(.WIDTH(W)) u_if ();

    booth_result_unloader u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard: words still owed for the captured product, {last, data}
    logic [W:0] exp_q[$];
    logic       exp_ovf;
    logic [W:0] act_q[$];
    int         n_total;
    int         n_bad;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model: words leave from the front, a product is accepted only
    // when nothing is still owed after this cycle's handshake
    task automatic model_step(input logic rst, input logic d, input logic [31:0] p, input logic rdy);
        if (rst) begin
            exp_q.delete();
            exp_ovf = 1'b0;
        end else begin
            if (exp_q.size() > 0 && rdy) void'(exp_q.pop_front());
            if (d) begin
                if (exp_q.size() == 0) begin
                    exp_q.push_back({1'b0, p[15:0]});
                    exp_q.push_back({1'b1, p[31:16]});
                end else begin
                    exp_ovf = 1'b1;
                end
            end
        end
    endtask

    task automatic compare_outputs(input string tag);
        check({tag, ".valid"}, 64'(u_if.out_valid), 64'(exp_q.size() > 0));
        check({tag, ".busy"}, 64'(u_if.busy), 64'(exp_q.size() > 0));
        check({tag, ".ovf"}, 64'(u_if.overflow), 64'(exp_ovf));
        if (exp_q.size() > 0) begin
            check({tag, ".data"}, 64'(u_if.out_data), 64'(exp_q[0][W-1:0]));
            check({tag, ".last"}, 64'(u_if.out_last), 64'(exp_q[0][W]));
        end
    endtask

    // driver: one clock with the given inputs, then model update and compare
    task automatic cycle(input logic rst, input logic d, input logic [31:0] p,
                         input logic rdy, input string tag);
        reset        = rst;
        u_if.done    = d;
        u_if.product = p;
        u_if.out_ready = rdy;
        #1;
        if (!rst && u_if.out_valid && rdy) act_q.push_back({u_if.out_last, u_if.out_data});
        @(posedge clk);
        model_step(rst, d, p, rdy);
        #1;
        compare_outputs(tag);
    endtask

    task automatic check_stream(input string tag, input logic [W:0] e0, input logic [W:0] e1,
                                input logic [W:0] e2, input logic [W:0] e3, input int n);
        logic [W:0] exp_words[4];
        exp_words = '{e0, e1, e2, e3};
        check({tag, ".len"}, 64'(act_q.size()), 64'(n));
        for (int i = 0; i < n && i < act_q.size(); i++)
            check($sformatf("%s.w%0d", tag, i), 64'(act_q[i]), 64'(exp_words[i]));
        act_q.delete();
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        exp_ovf = 1'b0;
        reset = 1'b1;
        u_if.done = 1'b0;
        u_if.product = '0;
        u_if.out_ready = 1'b0;

        cycle(1, 0, 0, 0, "rst");
        cycle(1, 0, 0, 0, "rst");
        check("rst.data0", 64'(u_if.out_data), 64'h0);
        check("rst.last0", 64'(u_if.out_last), 64'h0);
        check("rst.state", 64'(u_if.dbg_state), 64'(IDLE));

        // basic
        cycle(0, 1, 32'h1234_5678, 1, "basic");
        repeat (3) cycle(0, 0, 0, 1, "basic");
        check_stream("basic", {1'b0, 16'h5678}, {1'b1, 16'h1234}, '0, '0, 2);
        check("basic.busy_end", 64'(u_if.busy), 64'h0);

        // backpressure
        cycle(0, 1, 32'hDEAD_BEEF, 0, "bp");
        repeat (5) begin
            cycle(0, 0, 0, 0, "bp");
            check("bp.hold", 64'(u_if.out_data), 64'hBEEF);
        end
        repeat (3) cycle(0, 0, 0, 1, "bp");
        check_stream("bp", {1'b0, 16'hBEEF}, {1'b1, 16'hDEAD}, '0, '0, 2);
        check("bp.ovf", 64'(u_if.overflow), 64'h0);

        // back-to-back
        cycle(0, 1, 32'h0001_0002, 1, "b2b");
        cycle(0, 0, 0, 1, "b2b");
        cycle(0, 1, 32'h0003_0004, 1, "b2b");
        check("b2b.busy_mid", 64'(u_if.busy), 64'h1);
        cycle(0, 0, 0, 1, "b2b");
        cycle(0, 0, 0, 1, "b2b");
        cycle(0, 0, 0, 1, "b2b");
        check_stream("b2b", {1'b0, 16'h0002}, {1'b1, 16'h0001}, {1'b0, 16'h0004}, {1'b1, 16'h0003}, 4);

        // overflow
        cycle(0, 1, 32'hAAAA_5555, 0, "ovf");
        cycle(0, 1, 32'hFFFF_FFFF, 0, "ovf");
        repeat (4) cycle(0, 0, 0, 1, "ovf");
        check_stream("ovf", {1'b0, 16'h5555}, {1'b1, 16'hAAAA}, '0, '0, 2);
        check("ovf.sticky", 64'(u_if.overflow), 64'h1);

        // reset mid-operation
        cycle(0, 1, 32'h9876_5432, 1, "rmid");
        cycle(0, 0, 0, 1, "rmid");
        cycle(0, 0, 0, 0, "rmid");
        cycle(1, 0, 0, 0, "rmid");
        check("rmid.data0", 64'(u_if.out_data), 64'h0);
        check("rmid.ovf0", 64'(u_if.overflow), 64'h0);
        act_q.delete();
        cycle(0, 1, 32'h1111_2222, 1, "rmid");
        repeat (3) cycle(0, 0, 0, 1, "rmid");
        check_stream("rmid", {1'b0, 16'h2222}, {1'b1, 16'h1111}, '0, '0, 2);

        // reset priority over done
        cycle(1, 1, 32'h5A5A_A5A5, 1, "rprio");
        check("rprio.state", 64'(u_if.dbg_state), 64'(IDLE));
        cycle(0, 0, 0, 1, "rprio");
        act_q.delete();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) == 0), $urandom(),
                  ($urandom_range(0, 2) != 0), "rand");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
